// File: rtl/snake_step_controller.sv
// Two-snake game tick sequencer: snapshots the board register, resolves
// moves/collisions and streams single-word writes back to the register.
module snake_step_controller #(
  parameter int GRID_W = 10,
  parameter int GRID_H = 10,
  parameter int INIT1  = 11,
  parameter int INIT2  = 88
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [423:0] state_in,
  input  logic         init_req,
  input  logic         step_req,
  output logic         busy,
  output logic         done,
  output logic [31:0]  wr_value,
  output logic [31:0]  wr_index,
  output logic         wr_enable
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACC, S_CALC, S_INIT, S_MOVE, S_COLL, S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic         init_q, init_d;
  logic [199:0] cells_q, cells_d;
  logic [6:0]   h1_q, h1_d, h2_q, h2_d;
  logic [31:0]  len1_q, len1_d, len2_q, len2_d;
  logic [31:0]  stage_q, stage_d;
  logic [1:0]   dir1_q, dir1_d, dir2_q, dir2_d;
  logic         busy_q, busy_d, done_q, done_d;
  logic         wen_q, wen_d;
  logic [31:0]  widx_q, widx_d, wval_q, wval_d;
  logic [6:0]   n1, n2;
  logic         o1, o2;
  logic [2:0]   outcome;
  logic         unused;

  // Only position bits [6:0] and direction bits [1:0] carry meaning.
  assign unused = ^{state_in[231:207], state_in[263:239],
                    state_in[391:362], state_in[423:394]};

  function automatic logic [6:0] next_cell(input logic [6:0] pos,
                                           input logic [1:0] dir);
    logic [6:0] row, col;
    row = pos / 7'(GRID_W);
    col = pos % 7'(GRID_W);
    case (dir)
      2'd0: row = (row == 7'd0) ? 7'(GRID_H - 1) : row - 7'd1;
      2'd1: col = (col == 7'(GRID_W - 1)) ? 7'd0 : col + 7'd1;
      2'd2: row = (row == 7'(GRID_H - 1)) ? 7'd0 : row + 7'd1;
      default: col = (col == 7'd0) ? 7'(GRID_W - 1) : col - 7'd1;
    endcase
    return row * 7'(GRID_W) + col;
  endfunction

  function automatic logic [1:0] cell_at(input logic [199:0] c,
                                         input logic [6:0] n);
    logic [199:0] s;
    s = c >> {n, 1'b0};
    return s[1:0];
  endfunction

  // Next heads, occupancy and collision outcome from the snapshot.
  always_comb begin
    n1 = next_cell(h1_q, dir1_q);
    n2 = next_cell(h2_q, dir2_q);
    o1 = cell_at(cells_q, n1) != 2'd0;
    o2 = cell_at(cells_q, n2) != 2'd0;
    outcome = 3'd0;
    if (n1 == n2 || (o1 && o2)) outcome = 3'd4;
    else if (o1)                outcome = 3'd2;
    else if (o2)                outcome = 3'd3;
  end

  // Sequencer next state and snapshot capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    init_d  = init_q;
    cells_d = cells_q;
    h1_d    = h1_q;
    h2_d    = h2_q;
    len1_d  = len1_q;
    len2_d  = len2_q;
    stage_d = stage_q;
    dir1_d  = dir1_q;
    dir2_d  = dir2_q;
    case (state_q)
      S_IDLE: begin
        if (init_req) begin
          state_d = S_ACC;
          init_d  = 1'b1;
        end else if (step_req) begin
          state_d = S_ACC;
          init_d  = 1'b0;
          cells_d = state_in[199:0];
          h1_d    = state_in[206:200];
          h2_d    = state_in[238:232];
          len1_d  = state_in[295:264];
          len2_d  = state_in[327:296];
          stage_d = state_in[359:328];
          dir1_d  = state_in[361:360];
          dir2_d  = state_in[393:392];
        end
      end
      S_ACC: begin
        idx_d   = 4'd0;
        state_d = init_q ? S_INIT : S_CALC;
      end
      S_CALC: begin
        idx_d = 4'd0;
        if (stage_q != 32'd1)      state_d = S_DONE;
        else if (outcome != 3'd0)  state_d = S_COLL;
        else                       state_d = S_MOVE;
      end
      S_INIT: begin
        if (idx_q == 4'd8) state_d = S_DONE;
        else               idx_d = idx_q + 4'd1;
      end
      S_MOVE: begin
        if (idx_q == 4'd5) state_d = S_DONE;
        else               idx_d = idx_q + 4'd1;
      end
      S_COLL:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_DONE;
  end

  // Write port contents for the upcoming cycle, registered below.
  always_comb begin
    wen_d  = 1'b0;
    widx_d = 32'd0;
    wval_d = 32'd0;
    case (state_d)
      S_INIT: begin
        wen_d = 1'b1;
        case (idx_d)
          4'd0: begin widx_d = 32'(INIT1); wval_d = 32'd1; end
          4'd1: begin widx_d = 32'(INIT2); wval_d = 32'd2; end
          4'd2: begin widx_d = 32'd100; wval_d = 32'(INIT1); end
          4'd3: begin widx_d = 32'd101; wval_d = 32'(INIT2); end
          4'd4: begin widx_d = 32'd102; wval_d = 32'd1; end
          4'd5: begin widx_d = 32'd103; wval_d = 32'd1; end
          4'd6: begin widx_d = 32'd105; wval_d = 32'd1; end
          4'd7: begin widx_d = 32'd106; wval_d = 32'd3; end
          default: begin widx_d = 32'd104; wval_d = 32'd1; end
        endcase
      end
      S_MOVE: begin
        wen_d = 1'b1;
        case (idx_d)
          4'd0: begin widx_d = {25'd0, n1}; wval_d = 32'd1; end
          4'd1: begin widx_d = 32'd100; wval_d = {25'd0, n1}; end
          4'd2: begin widx_d = 32'd102; wval_d = len1_q + 32'd1; end
          4'd3: begin widx_d = {25'd0, n2}; wval_d = 32'd2; end
          4'd4: begin widx_d = 32'd101; wval_d = {25'd0, n2}; end
          default: begin widx_d = 32'd103; wval_d = len2_q + 32'd1; end
        endcase
      end
      S_COLL: begin
        wen_d  = 1'b1;
        widx_d = 32'd104;
        wval_d = {29'd0, outcome};
      end
      default: ;
    endcase
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      init_q  <= 1'b0;
      cells_q <= '0;
      h1_q    <= '0;
      h2_q    <= '0;
      len1_q  <= '0;
      len2_q  <= '0;
      stage_q <= '0;
      dir1_q  <= '0;
      dir2_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wen_q   <= 1'b0;
      widx_q  <= '0;
      wval_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      init_q  <= init_d;
      cells_q <= cells_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      len1_q  <= len1_d;
      len2_q  <= len2_d;
      stage_q <= stage_d;
      dir1_q  <= dir1_d;
      dir2_q  <= dir2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wen_q   <= wen_d;
      widx_q  <= widx_d;
      wval_q  <= wval_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_enable = wen_q;
  assign wr_index  = widx_q;
  assign wr_value  = wval_q;

endmodule

// File: tb/tb_snake_step_controller.sv
// Scoreboard bench for snake_step_controller: a game-level model queues
// expected writes and latencies, a monitor drains them as the DUT writes.
module tb_snake_step_controller;
  localparam int W = 10;
  localparam int H = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [423:0] state_in = '0;
  logic         init_req = 1'b0;
  logic         step_req = 1'b0;
  logic         busy, done, wr_enable;
  logic [31:0]  wr_value, wr_index;

  snake_step_controller #(
    .GRID_W(10), .GRID_H(10), .INIT1(11), .INIT2(88)
  ) dut (
    .clock(clock), .reset(reset), .state_in(state_in),
    .init_req(init_req), .step_req(step_req),
    .busy(busy), .done(done),
    .wr_value(wr_value), .wr_index(wr_index), .wr_enable(wr_enable)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int acc_cyc = 0;
  int done_seen = 0;
  logic [31:0] exp_idx[$];
  logic [31:0] exp_val[$];
  int exp_lat[$];
  int board[100];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(int idx, logic [31:0] val);
    exp_idx.push_back(32'(idx));
    exp_val.push_back(val);
  endtask

  // Monitor: every write and every done pulse is matched to the model.
  initial forever begin
    @(negedge clock);
    if (wr_enable === 1'b1) begin
      if (exp_idx.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_write: got index %0d value %0d, expected none",
                 wr_index, wr_value);
      end else begin
        chk("wr_index", wr_index, exp_idx.pop_front());
        chk("wr_value", wr_value, exp_val.pop_front());
      end
    end
    if (done === 1'b1) begin
      chk("writes_left_at_done", 32'(exp_idx.size()), 32'd0);
      chk("busy_at_done", {31'd0, busy}, 32'd1);
      if (exp_lat.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_done: got done pulse, expected none");
      end else begin
        chk("latency", 32'(cyc - acc_cyc), 32'(exp_lat.pop_front()));
      end
      done_seen++;
    end
  end

  function automatic int nxt(int pos, int dir);
    int r, c;
    r = pos / W;
    c = pos % W;
    case (dir)
      0: r = (r + H - 1) % H;
      1: c = (c + 1) % W;
      2: r = (r + 1) % H;
      default: c = (c + W - 1) % W;
    endcase
    return r * W + c;
  endfunction

  task automatic issue(bit do_init, bit do_step);
    @(negedge clock);
    init_req = do_init;
    step_req = do_step;
    acc_cyc = cyc + 1;
    @(negedge clock);
    init_req = 1'b0;
    step_req = 1'b0;
  endtask

  task automatic wait_done(string name);
    int start;
    bit ok;
    start = done_seen;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      #1;
      if (done_seen != start) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: no done in 40 cycles, expected a pulse", name);
      exp_idx.delete();
      exp_val.delete();
      exp_lat.delete();
    end
    @(posedge clock);
    #1;
    chk({name, "_busy_off"}, {31'd0, busy}, 32'd0);
    chk({name, "_done_off"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run_init(bit with_step);
    push(11, 1);
    push(88, 2);
    push(100, 11);
    push(101, 88);
    push(102, 1);
    push(103, 1);
    push(105, 1);
    push(106, 3);
    push(104, 1);
    exp_lat.push_back(10);
    issue(1'b1, with_step);
    wait_done("init");
  endtask

  task automatic clear_board();
    for (int i = 0; i < 100; i++) board[i] = 0;
  endtask

  // Model one tick at the game level and queue what the DUT must write.
  task automatic setup_step(int h1, int d1, int h2, int d2,
                            logic [31:0] l1, logic [31:0] l2, int stg);
    int n1, n2;
    bit o1, o2;
    logic [423:0] s;
    s = '0;
    for (int i = 0; i < 100; i++) s[2*i +: 2] = 2'(board[i]);
    s[231:200] = 32'(h1);
    s[263:232] = 32'(h2);
    s[295:264] = l1;
    s[327:296] = l2;
    s[359:328] = 32'(stg);
    s[391:360] = 32'(d1);
    s[423:392] = 32'(d2);
    state_in = s;
    n1 = nxt(h1, d1);
    n2 = nxt(h2, d2);
    o1 = board[n1] != 0;
    o2 = board[n2] != 0;
    if (stg != 1) begin
      exp_lat.push_back(2);
    end else if (n1 == n2 || (o1 && o2)) begin
      push(104, 4);
      exp_lat.push_back(3);
    end else if (o1) begin
      push(104, 2);
      exp_lat.push_back(3);
    end else if (o2) begin
      push(104, 3);
      exp_lat.push_back(3);
    end else begin
      push(n1, 1);
      push(100, 32'(n1));
      push(102, l1 + 32'd1);
      push(n2, 2);
      push(101, 32'(n2));
      push(103, l2 + 32'd1);
      exp_lat.push_back(8);
    end
  endtask

  task automatic run_step(int h1, int d1, int h2, int d2,
                          logic [31:0] l1, logic [31:0] l2, int stg);
    setup_step(h1, d1, h2, d2, l1, l2, stg);
    issue(1'b0, 1'b1);
    wait_done("step");
  endtask

  initial begin
    clear_board();
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wen", {31'd0, wr_enable}, 32'd0);
    chk("rst_widx", wr_index, 32'd0);
    chk("rst_wval", wr_value, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    run_init(1'b0);

    run_step(11, 1, 88, 3, 32'd1, 32'd1, 1);

    run_step(9, 1, 55, 0, 32'd4, 32'd7, 1);
    run_step(0, 0, 99, 2, 32'hFFFF_FFFF, 32'd3, 1);

    run_step(44, 1, 46, 3, 32'd2, 32'd2, 1);

    board[12] = 2;
    run_step(11, 1, 70, 0, 32'd2, 32'd2, 1);
    run_step(11, 1, 70, 0, 32'd2, 32'd2, 2);
    board[59] = 3;
    run_step(20, 0, 69, 0, 32'd2, 32'd2, 1);
    board[10] = 1;
    run_step(11, 3, 69, 0, 32'd2, 32'd2, 1);

    run_init(1'b1);

    clear_board();
    setup_step(11, 1, 88, 3, 32'd5, 32'd6, 1);
    issue(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (cyc == acc_cyc + 4) break;
      @(negedge clock);
    end
    #2;
    reset = 1'b0;
    #1;
    chk("mid_writes_left", 32'(exp_idx.size()), 32'd3);
    chk("mid_wen", {31'd0, wr_enable}, 32'd0);
    chk("mid_widx", wr_index, 32'd0);
    chk("mid_wval", wr_value, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    exp_idx.delete();
    exp_val.delete();
    exp_lat.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    run_init(1'b0);

    for (int t = 0; t < 40; t++) begin
      int h1, h2, d1, d2, stg;
      logic [31:0] l1, l2;
      for (int i = 0; i < 100; i++)
        board[i] = ($urandom_range(0, 99) < 15) ? $urandom_range(1, 3) : 0;
      h1 = $urandom_range(0, 99);
      h2 = $urandom_range(0, 99);
      d1 = $urandom_range(0, 3);
      d2 = $urandom_range(0, 3);
      l1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      l2 = 32'($urandom_range(0, 200));
      stg = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 4) : 1;
      run_step(h1, d1, h2, d2, l1, l2, stg);
    end

    repeat (3) @(negedge clock);
    chk("final_queue_empty", 32'(exp_idx.size() + exp_lat.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
